sound_sequencer: RTL and testbench
==================================

// Module: sound_sequencer
// PURPOSE
//  Plays short jingles on the snake game's piezo output. Three requesters (start, eat, death) share one tone generator.
//  Fixed priority; a higher-priority request pre-empts the current jingle. Each jingle is 4 notes read from a constant ROM.
//  Each note drives an internal programmable square-wave divider for NOTE_TICKS cycles.
//  Sits between game-FSM event strobes and the board audio pin.
// PARAMETERS
//  NOTE_TICKS        12_500_000  clock cycles per note (125 ms @ 100 MHz); must be >= 2
//  TONE_SCALE_SHIFT  0           ROM half-period is right-shifted by this amount before use (sim speed-up only)
//  PERIOD_W          20          width of half-period counter; ROM entries must fit
// PORTS
//  in_clock        in   1  system clock, 100 MHz
//  in_reset_n      in   1  asynchronous, active-low reset
//  in_req          in   3  event strobes: [0]=start, [1]=eat, [2]=death (2 = highest priority); level or pulse
//  in_mute         in   1  1 = force out_audio low; sequencing continues unchanged
//  out_audio       out  1  square wave to piezo
//  out_busy        out  1  1 while a jingle is playing
//  out_active_id   out  2  0 = none, 1 = start, 2 = eat, 3 = death
//  out_done        out  1  one-cycle pulse when a jingle completes normally (not when aborted)
// BEHAVIOUR
//  Reset (async, in_reset_n=0): state IDLE; pending=0; all outputs 0; counters 0. Takes effect mid-note with no wait.
//  Request capture: each clock, pending[i] |= in_req[i]. The exception is i == active source, which is ignored while that source plays.
//  FSM states: IDLE -> LOAD -> PLAY -> (LOAD | IDLE).
//   IDLE: if pending != 0, take the highest set bit as the source, clear its pending bit, set note_idx=0, go LOAD.
//   LOAD: one cycle. Half-period H = ROM[src][note_idx] >> TONE_SCALE_SHIFT. Load the divider (count=0, tone=0).
//         Clear the duration counter. out_busy=1 and out_active_id=src from this cycle. Go PLAY.
//   PLAY: duration counts 0..NOTE_TICKS-1. At NOTE_TICKS-1:
//         if note_idx<3, note_idx++ and go LOAD;
//         else pulse out_done, then either go LOAD with a new source (pending!=0, same cycle, no IDLE visit)
//         or go IDLE (out_busy=0, out_active_id=0).
//  Pre-emption: in LOAD or PLAY, a pending bit above the active source aborts the current jingle.
//   The next state is LOAD for the new source with note_idx=0. No out_done pulse. The aborted source is not re-queued.
//  Lower-priority pending bits are held until the current jingle ends.
//  Simultaneous events:
//   - multiple bits of in_req in IDLE: highest wins; others stay pending.
//   - a request arriving on the final PLAY cycle is seen in that cycle's pending decision.
//  Tone divider:
//   - H==0 (REST): out tone is held 0.
//   - H>0: count 0..H-1; at H-1 the tone toggles and count returns to 0. Output period = 2*H cycles.
//   - First toggle is H cycles after LOAD.
//   - H is reloaded only in LOAD.
//  out_audio = tone & ~in_mute & busy. Registered, so 1 cycle after the tone register.
//  Widths: duration counter is ceil(log2(NOTE_TICKS)) bits. Shift is applied before compare; no overflow is possible.
// STRUCTURE
//  Package sound_pkg:
//   - note constants, 100 MHz half-periods: NOTE_C5=95_602, NOTE_E5=75_843, NOTE_G5=63_776, NOTE_C6=47_801, NOTE_REST=0
//   - source id localparams: SRC_NONE=0, SRC_START=1, SRC_EAT=2, SRC_DEATH=3
//   - state encoding: IDLE=0, LOAD=1, PLAY=2
//   - jingle ROM (index [src][note]): START = C5,E5,G5,C6; EAT = G5,C6,REST,REST; DEATH = C6,G5,E5,C5
//  Sub-module tone_divider (in_clock, in_reset_n, in_load, in_half_period[PERIOD_W-1:0], out_tone).
//  Sequencer FSM, pending register and duration counter live in sound_sequencer.
// TESTING  (bench: NOTE_TICKS=200, TONE_SCALE_SHIFT=12 -> H: C5=23, E5=18, G5=15, C6=11)
//  1 Reset:
//    in_reset_n=0 mid-PLAY -> out_audio, out_busy, out_done = 0 and out_active_id = 0 immediately.
//    After release, stays IDLE with no request.
//  2 in_req=3'b001 pulse -> out_active_id=1; out_audio periods 46, 36, 30, 22 cycles in order.
//    out_done pulses once 4*201 cycles after LOAD; out_busy=0 the next cycle.
//  3 in_req=3'b010 -> notes 3,4 are rests: out_audio stays 0 for 400 cycles. out_done pulses at end.
//  4 Start playing, then in_req=3'b100 at note 2 -> next cycle LOAD with out_active_id=3, no out_done.
//    Death jingle plays (periods 22, 30, 36, 46). Start is not replayed afterward.
//  5 in_req=3'b011 in the same cycle -> eat plays first, then start in back-to-back LOAD with no IDLE cycle.
//    out_done pulses twice.
//  6 in_mute=1 during eat jingle -> out_audio=0 throughout, but out_busy/out_done timing is identical to scenario 3.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared constants for the snake-game jingle player: note half-periods, source ids,
// FSM encoding and the jingle ROM lookup.
package sound_pkg;

  typedef logic [1:0] src_id_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;

  localparam src_id_t SRC_NONE  = 2'd0;
  localparam src_id_t SRC_START = 2'd1;
  localparam src_id_t SRC_EAT   = 2'd2;
  localparam src_id_t SRC_DEATH = 2'd3;

  // Half-periods in 100 MHz clock cycles
  localparam logic [31:0] NOTE_C5   = 32'd95_602;
  localparam logic [31:0] NOTE_E5   = 32'd75_843;
  localparam logic [31:0] NOTE_G5   = 32'd63_776;
  localparam logic [31:0] NOTE_C6   = 32'd47_801;
  localparam logic [31:0] NOTE_REST = 32'd0;

  function automatic logic [2:0] src_mask(input src_id_t src);
    case (src)
      SRC_START: src_mask = 3'b001;
      SRC_EAT:   src_mask = 3'b010;
      SRC_DEATH: src_mask = 3'b100;
      default:   src_mask = 3'b000;
    endcase
  endfunction

  // Request bit 2 outranks bit 1 outranks bit 0; ids are ordered the same way
  function automatic src_id_t highest_src(input logic [2:0] req);
    if (req[2])      highest_src = SRC_DEATH;
    else if (req[1]) highest_src = SRC_EAT;
    else if (req[0]) highest_src = SRC_START;
    else             highest_src = SRC_NONE;
  endfunction

  function automatic logic [31:0] jingle_half_period(input src_id_t src, input logic [1:0] idx);
    jingle_half_period = NOTE_REST;
    case (src)
      SRC_START:
        case (idx)
          2'd0:    jingle_half_period = NOTE_C5;
          2'd1:    jingle_half_period = NOTE_E5;
          2'd2:    jingle_half_period = NOTE_G5;
          default: jingle_half_period = NOTE_C6;
        endcase
      SRC_EAT:
        case (idx)
          2'd0:    jingle_half_period = NOTE_G5;
          2'd1:    jingle_half_period = NOTE_C6;
          default: jingle_half_period = NOTE_REST;
        endcase
      SRC_DEATH:
        case (idx)
          2'd0:    jingle_half_period = NOTE_C6;
          2'd1:    jingle_half_period = NOTE_G5;
          2'd2:    jingle_half_period = NOTE_E5;
          default: jingle_half_period = NOTE_C5;
        endcase
      default: jingle_half_period = NOTE_REST;
    endcase
  endfunction

endpackage

// File: rtl/sound_sequencer_tone_divider.sv
// Programmable square-wave divider: toggles every in_half_period cycles, silent when
// the half-period is zero. The half-period is captured only on in_load.
module tone_divider #(
  parameter int PERIOD_W = 20
) (
  input  logic                in_clock,
  input  logic                in_reset_n,
  input  logic                in_load,
  input  logic [PERIOD_W-1:0] in_half_period,
  output logic                out_tone
);

  logic [PERIOD_W-1:0] half;
  logic [PERIOD_W-1:0] count;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      half     <= '0;
      count    <= '0;
      out_tone <= 1'b0;
    end else if (in_load) begin
      half     <= in_half_period;
      count    <= '0;
      out_tone <= 1'b0;
    end else if (half == '0) begin
      count    <= '0;
      out_tone <= 1'b0;
    end else if (count == half - PERIOD_W'(1)) begin
      count    <= '0;
      out_tone <= ~out_tone;
    end else begin
      count    <= count + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/sound_sequencer.sv
// Fixed-priority jingle sequencer: captures start/eat/death strobes, plays a 4-note
// jingle per source through a shared tone divider, higher priority pre-empts.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int NOTE_TICKS       = 12_500_000,
  parameter int TONE_SCALE_SHIFT = 0,
  parameter int PERIOD_W         = 20
) (
  input  logic       in_clock,
  input  logic       in_reset_n,
  input  logic [2:0] in_req,
  input  logic       in_mute,
  output logic       out_audio,
  output logic       out_busy,
  output logic [1:0] out_active_id,
  output logic       out_done
);

  localparam int DUR_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(NOTE_TICKS - 1);

  logic [1:0]          state, state_d;
  src_id_t             src, src_d;
  logic [1:0]          note_idx, note_idx_d;
  logic [DUR_W-1:0]    dur;
  logic [2:0]          pending, pending_d;
  logic                take;

  logic                playing;
  logic [2:0]          req_all;
  src_id_t             top_src;
  logic                preempt;
  logic                note_end;
  logic                jingle_done;
  logic [PERIOD_W-1:0] half_period;
  logic                tone;

  assign playing = (state != ST_IDLE);

  // A request for the source already playing is dropped; everything else is seen this cycle
  assign req_all     = pending | (in_req & ~(playing ? src_mask(src) : 3'b000));
  assign top_src     = highest_src(req_all);
  assign preempt     = playing && (top_src > src);
  assign note_end    = (state == ST_PLAY) && (dur == DUR_LAST);
  assign jingle_done = note_end && (note_idx == 2'd3);

  always_comb begin
    state_d    = state;
    src_d      = src;
    note_idx_d = note_idx;
    take       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (top_src != SRC_NONE) begin
          state_d    = ST_LOAD;
          src_d      = top_src;
          note_idx_d = 2'd0;
          take       = 1'b1;
        end
      end
      ST_LOAD: begin
        if (preempt) begin
          src_d      = top_src;
          note_idx_d = 2'd0;
          take       = 1'b1;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // A jingle finishing on this very cycle completes normally before any hand-over
        if (jingle_done) begin
          if (top_src != SRC_NONE) begin
            state_d    = ST_LOAD;
            src_d      = top_src;
            note_idx_d = 2'd0;
            take       = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            src_d      = SRC_NONE;
            note_idx_d = 2'd0;
          end
        end else if (preempt) begin
          state_d    = ST_LOAD;
          src_d      = top_src;
          note_idx_d = 2'd0;
          take       = 1'b1;
        end else if (note_end) begin
          state_d    = ST_LOAD;
          note_idx_d = note_idx + 2'd1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        src_d      = SRC_NONE;
        note_idx_d = 2'd0;
      end
    endcase
    pending_d = req_all & ~(take ? src_mask(top_src) : 3'b000);
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state    <= ST_IDLE;
      src      <= SRC_NONE;
      note_idx <= 2'd0;
      pending  <= 3'b000;
      dur      <= '0;
    end else begin
      state    <= state_d;
      src      <= src_d;
      note_idx <= note_idx_d;
      pending  <= pending_d;
      if (state == ST_PLAY)
        dur <= dur + DUR_W'(1);
      else
        dur <= '0;
    end
  end

  assign half_period = PERIOD_W'(jingle_half_period(src, note_idx) >> TONE_SCALE_SHIFT);

  tone_divider #(
    .PERIOD_W(PERIOD_W)
  ) u_tone_divider (
    .in_clock      (in_clock),
    .in_reset_n    (in_reset_n),
    .in_load       (state == ST_LOAD),
    .in_half_period(half_period),
    .out_tone      (tone)
  );

  // Output stage: gated tone registered once more before the pin
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n)
      out_audio <= 1'b0;
    else
      out_audio <= tone & ~in_mute & playing;
  end

  assign out_busy      = playing;
  assign out_active_id = playing ? src : SRC_NONE;
  assign out_done      = jingle_done;

endmodule

// File: tb/tb_sound_sequencer.sv
// Scenario bench for sound_sequencer with short notes and scaled-down tones.
module tb_sound_sequencer;

  localparam int NOTE_TICKS = 200;
  localparam int NOTE_LEN   = NOTE_TICKS + 1;

  logic       in_clock = 1'b0;
  logic       in_reset_n;
  logic [2:0] in_req;
  logic       in_mute;
  logic       out_audio;
  logic       out_busy;
  logic [1:0] out_active_id;
  logic       out_done;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  sound_sequencer #(
    .NOTE_TICKS      (NOTE_TICKS),
    .TONE_SCALE_SHIFT(12),
    .PERIOD_W        (20)
  ) dut (
    .in_clock     (in_clock),
    .in_reset_n   (in_reset_n),
    .in_req       (in_req),
    .in_mute      (in_mute),
    .out_audio    (out_audio),
    .out_busy     (out_busy),
    .out_active_id(out_active_id),
    .out_done     (out_done)
  );

  always #5 in_clock = ~in_clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  task automatic tick;
    @(negedge in_clock);
  endtask

  task automatic pulse_req(input logic [2:0] r);
    in_req = r;
    tick;
    in_req = 3'b000;
  endtask

  // Follows one jingle from its LOAD cycle to its last cycle, popping one expected
  // half-period-derived period per note, then checks what comes right after.
  task automatic mon_jingle(input logic [1:0] id, input logic [1:0] next_id);
    int waited;
    int r0, r1, meas, expv, bad_busy, bad_done;
    bit hi, prev, exp_done;
    waited = 0;
    while (!out_busy && waited < 20) begin
      tick;
      waited++;
    end
    n_cmp++;
    if (out_busy !== 1'b1 || out_active_id !== id) begin
      n_err++;
      $display("FAIL start_id%0d: busy=%0b id=%0d, required busy=1 id=%0d", id, out_busy, out_active_id, id);
    end
    for (int n = 0; n < 4; n++) begin
      r0 = -1; r1 = -1; hi = 0; bad_busy = 0; bad_done = 0;
      prev = out_audio;
      for (int off = 0; off < NOTE_LEN; off++) begin
        if (out_busy !== 1'b1 || out_active_id !== id) bad_busy++;
        exp_done = (n == 3 && off == NOTE_LEN - 1);
        if (out_done !== exp_done) bad_done++;
        if (off >= 2) begin
          if (out_audio === 1'b1) hi = 1;
          if (out_audio === 1'b1 && prev == 1'b0) begin
            if (r0 < 0) r0 = off;
            else if (r1 < 0) r1 = off;
          end
        end
        prev = out_audio;
        if (!(n == 3 && off == NOTE_LEN - 1)) tick;
      end
      if (r1 >= 0) meas = r1 - r0;
      else if (hi) meas = -1;
      else meas = 0;
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : -99;
      n_cmp++;
      if (meas !== expv) begin
        n_err++;
        $display("FAIL period_id%0d_note%0d: got %0d, required %0d", id, n, meas, expv);
      end
      n_cmp++;
      if (bad_busy != 0) begin
        n_err++;
        $display("FAIL busy_id%0d_note%0d: %0d bad cycles, required 0", id, n, bad_busy);
      end
      n_cmp++;
      if (bad_done != 0) begin
        n_err++;
        $display("FAIL done_id%0d_note%0d: %0d bad cycles, required 0", id, n, bad_done);
      end
    end
    tick;
    n_cmp++;
    if (out_busy !== (next_id != 2'd0) || out_active_id !== next_id || out_done !== 1'b0) begin
      n_err++;
      $display("FAIL after_id%0d: busy=%0b id=%0d done=%0b, required busy=%0b id=%0d done=0",
               id, out_busy, out_active_id, out_done, next_id != 2'd0, next_id);
    end
  endtask

  task automatic test_reset;
    int idle_bad, waited;
    in_reset_n = 1'b0;
    in_req     = 3'b000;
    in_mute    = 1'b0;
    tick; tick;
    n_cmp++;
    if ({out_audio, out_busy, out_active_id, out_done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, required 00000", {out_audio, out_busy, out_active_id, out_done});
    end
    in_reset_n = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (out_busy !== 1'b0 || out_active_id !== 2'd0) idle_bad++;
    end
    n_cmp++;
    if (idle_bad != 0) begin
      n_err++;
      $display("FAIL idle_after_reset: %0d busy cycles, required 0", idle_bad);
    end
    pulse_req(3'b001);
    waited = 0;
    while (!(out_busy === 1'b1 && out_audio === 1'b1) && waited < 400) begin
      tick;
      waited++;
    end
    n_cmp++;
    if (waited >= 400) begin
      n_err++;
      $display("FAIL reset_setup: audio never high, required high within 400 cycles");
    end
    in_reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_audio, out_busy, out_active_id, out_done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_midplay: got %b, required 00000", {out_audio, out_busy, out_active_id, out_done});
    end
    tick; tick;
    in_reset_n = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (out_busy !== 1'b0 || out_audio !== 1'b0) idle_bad++;
    end
    n_cmp++;
    if (idle_bad != 0) begin
      n_err++;
      $display("FAIL idle_after_midplay_reset: %0d active cycles, required 0", idle_bad);
    end
  endtask

  task automatic test_start;
    exp_q.push_back(46); exp_q.push_back(36); exp_q.push_back(30); exp_q.push_back(22);
    pulse_req(3'b001);
    mon_jingle(2'd1, 2'd0);
  endtask

  task automatic test_eat;
    exp_q.push_back(30); exp_q.push_back(22); exp_q.push_back(0); exp_q.push_back(0);
    pulse_req(3'b010);
    mon_jingle(2'd2, 2'd0);
  endtask

  task automatic test_preempt;
    int waited, done_seen, replay;
    pulse_req(3'b001);
    waited = 0;
    while (!out_busy && waited < 20) begin
      tick;
      waited++;
    end
    done_seen = 0;
    for (int i = 0; i < 2 * NOTE_LEN + 60; i++) begin
      if (out_done === 1'b1) done_seen++;
      tick;
    end
    n_cmp++;
    if (out_active_id !== 2'd1 || out_busy !== 1'b1) begin
      n_err++;
      $display("FAIL preempt_setup: id=%0d busy=%0b, required id=1 busy=1", out_active_id, out_busy);
    end
    exp_q.push_back(22); exp_q.push_back(30); exp_q.push_back(36); exp_q.push_back(46);
    in_req = 3'b100;
    if (out_done === 1'b1) done_seen++;
    tick;
    in_req = 3'b000;
    if (out_done === 1'b1) done_seen++;
    n_cmp++;
    if (out_active_id !== 2'd3 || out_busy !== 1'b1) begin
      n_err++;
      $display("FAIL preempt_switch: id=%0d busy=%0b, required id=3 busy=1", out_active_id, out_busy);
    end
    n_cmp++;
    if (done_seen != 0) begin
      n_err++;
      $display("FAIL preempt_no_done: %0d done pulses, required 0", done_seen);
    end
    mon_jingle(2'd3, 2'd0);
    replay = 0;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (out_busy !== 1'b0) replay++;
    end
    n_cmp++;
    if (replay != 0) begin
      n_err++;
      $display("FAIL preempt_no_replay: %0d busy cycles, required 0", replay);
    end
  endtask

  task automatic test_back_to_back;
    exp_q.push_back(30); exp_q.push_back(22); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(46); exp_q.push_back(36); exp_q.push_back(30); exp_q.push_back(22);
    pulse_req(3'b011);
    mon_jingle(2'd2, 2'd1);
    mon_jingle(2'd1, 2'd0);
  endtask

  task automatic test_mute;
    in_mute = 1'b1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    pulse_req(3'b010);
    mon_jingle(2'd2, 2'd0);
    in_mute = 1'b0;
  endtask

  initial begin
    test_reset;
    test_start;
    test_eat;
    test_preempt;
    test_back_to_back;
    test_mute;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
